// File: rtl/or1k_wb_ext_responder.sv
// rtl/or1k_wb_ext_responder.sv - shared-SRAM Wishbone B3 responder for the per-tile wb_ext_* master ports
// Optional burst support (incrementing/wrapping) is built only when OR1K_WB_EXT_RESPONDER_BURST_EN is defined.
module or1k_wb_ext_responder #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int NODES     = 4,
   parameter int MEM_WORDS = 4096
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NODES-1:0][AW-1:0]       wb_ext_adr_i,
   input  logic [NODES-1:0]               wb_ext_cyc_i,
   input  logic [NODES-1:0][DW-1:0]       wb_ext_dat_i,
   input  logic [NODES-1:0][DW/8-1:0]     wb_ext_sel_i,
   input  logic [NODES-1:0]               wb_ext_stb_i,
   input  logic [NODES-1:0]               wb_ext_we_i,
   input  logic [NODES-1:0]               wb_ext_cab_i,
   input  logic [NODES-1:0][2:0]          wb_ext_cti_i,
   input  logic [NODES-1:0][1:0]          wb_ext_bte_i,
   output logic [NODES-1:0]               wb_ext_ack_o,
   output logic [NODES-1:0]               wb_ext_rty_o,
   output logic [NODES-1:0]               wb_ext_err_o,
   output logic [NODES-1:0][DW-1:0]       wb_ext_dat_o
);

   localparam int IW = $clog2(MEM_WORDS);
   localparam int GW = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int BW = DW / 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACK  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [DW-1:0]    mem [MEM_WORDS];

   logic [1:0]       state;
   logic [GW-1:0]    grant;
   logic [GW-1:0]    last_grant;
   logic [GW-1:0]    pick;
   logic             found;
   logic [IW-1:0]    addr;
   logic             oor_q;
   logic             resp_q;
   logic [DW-1:0]    dat_q;
   logic [NODES-1:0] req;

   logic             g_cyc;
   logic             g_stb;
   logic             g_we;
   logic [DW-1:0]    g_dat;
   logic [BW-1:0]    g_sel;
   logic [IW-1:0]    g_word;
   logic             g_oor;
   logic [IW-1:0]    p_word;
   logic             p_oor;
   logic             beat_done;
   logic             burst_more;
   logic             unused_inputs;

   assign req       = wb_ext_cyc_i & wb_ext_stb_i;
   assign g_cyc     = wb_ext_cyc_i[grant];
   assign g_stb     = wb_ext_stb_i[grant];
   assign g_we      = wb_ext_we_i[grant];
   assign g_dat     = wb_ext_dat_i[grant];
   assign g_sel     = wb_ext_sel_i[grant];
   assign g_word    = wb_ext_adr_i[grant][IW+1:2];
   assign g_oor     = |wb_ext_adr_i[grant][AW-1:IW+2];
   assign p_word    = wb_ext_adr_i[pick][IW+1:2];
   assign p_oor     = |wb_ext_adr_i[pick][AW-1:IW+2];
   assign beat_done = (state == ACK) && resp_q && g_cyc && g_stb;

   // Round-robin search begins just past the previous winner.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = last_grant;
      for (int k = 1; k <= NODES; k++) begin
         idx = (int'(last_grant) + k) % NODES;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
   end

`ifdef OR1K_WB_EXT_RESPONDER_BURST_EN
   logic [2:0]    g_cti;
   logic [1:0]    g_bte;
   logic [IW-1:0] addr_next;

   assign g_cti      = wb_ext_cti_i[grant];
   assign g_bte      = wb_ext_bte_i[grant];
   assign burst_more = beat_done && (g_cti == 3'b010);

   // Wrapping bursts only step the low index bits; linear wraps at the end of the SRAM.
   always_comb begin
      addr_next = addr + IW'(1);
      case (g_bte)
         2'b01:   addr_next = {addr[IW-1:2], addr[1:0] + 2'd1};
         2'b10:   addr_next = {addr[IW-1:3], addr[2:0] + 3'd1};
         2'b11:   addr_next = {addr[IW-1:4], addr[3:0] + 4'd1};
         default: ;
      endcase
   end

   assign unused_inputs = ^{wb_ext_cab_i, wb_ext_adr_i};
`else
   assign burst_more    = 1'b0;
   assign unused_inputs = ^{wb_ext_cab_i, wb_ext_adr_i, wb_ext_cti_i, wb_ext_bte_i};
`endif

   // A beat is written only when it completes; a reset on that edge drops it.
   always_ff @(posedge clk) begin
      if (!rst && beat_done && g_we && !oor_q) begin
         for (int b = 0; b < BW; b++) begin
            if (g_sel[b]) mem[addr][8*b +: 8] <= g_dat[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= GW'(NODES - 1);
         last_grant <= GW'(NODES - 1);
         addr       <= '0;
         oor_q      <= 1'b0;
         resp_q     <= 1'b0;
         dat_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant      <= pick;
                  last_grant <= pick;
                  addr       <= p_word;
                  oor_q      <= p_oor;
                  resp_q     <= 1'b1;
                  if (!wb_ext_we_i[pick]) dat_q <= mem[p_word];
                  state      <= ACK;
               end
            end
            ACK: begin
               if (!g_cyc) begin
                  resp_q <= 1'b0;
                  state  <= IDLE;
               end else if (resp_q && !g_stb) begin
                  resp_q <= 1'b0;
               end else if (!resp_q && g_stb) begin
                  resp_q <= 1'b1;
               end else if (beat_done) begin
`ifdef OR1K_WB_EXT_RESPONDER_BURST_EN
                  if (burst_more) begin
                     addr <= addr_next;
                     if (!g_we) dat_q <= mem[addr_next];
                  end else begin
                     resp_q <= 1'b0;
                     state  <= WAIT;
                  end
`else
                  resp_q <= burst_more;
                  state  <= WAIT;
`endif
               end
            end
            WAIT: begin
               if (!g_cyc) begin
                  state <= IDLE;
               end else if (g_stb) begin
                  addr   <= g_word;
                  oor_q  <= g_oor;
                  resp_q <= 1'b1;
                  if (!g_we) dat_q <= mem[g_word];
                  state  <= ACK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      wb_ext_ack_o = '0;
      wb_ext_err_o = '0;
      wb_ext_rty_o = '0;
      if (resp_q) begin
         if (oor_q) wb_ext_err_o[grant] = 1'b1;
         else       wb_ext_ack_o[grant] = 1'b1;
      end
      for (int n = 0; n < NODES; n++) wb_ext_dat_o[n] = dat_q;
   end

endmodule
